// File: rtl/sensor_cfg_seq.sv
// sensor_cfg_seq: walks an external register ROM and writes each entry over SCCB,
// honouring delay entries, retrying NACKed writes and reporting done/error status.
module sensor_cfg_seq #(
    parameter int          TABLE_LEN  = 256,
    parameter int          ADDR_W     = 8,
    parameter logic [7:0]  DEV_ADDR   = 8'h78,
    parameter logic [15:0] DELAY_MARK = 16'hFFFF,
    parameter int          DELAY_UNIT = 24000,
    parameter int          MAX_RETRY  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              power_on_vd,
    input  logic              start_cfg,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_data,
    output logic              sccb_req,
    output logic [7:0]        sccb_dev,
    output logic [15:0]       sccb_reg,
    output logic [7:0]        sccb_wdata,
    input  logic              sccb_done,
    input  logic              sccb_nack,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic [ADDR_W-1:0] cfg_index
);
    localparam int RW = $clog2(MAX_RETRY + 1);
    typedef enum logic [3:0] {
        IDLE, FETCH, WAIT_ROM, DECODE, REQ, WAIT_ACK, GAP, DELAY, NEXT, DONE, ERR
    } state_t;
    state_t        state;
    logic          pv_q;
    logic [RW-1:0] retry;
    logic [31:0]   dly;
    assign sccb_dev = DEV_ADDR;
    assign rom_addr = cfg_index;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pv_q       <= 1'b0;
            retry      <= '0;
            dly        <= '0;
            cfg_index  <= '0;
            sccb_req   <= 1'b0;
            sccb_reg   <= '0;
            sccb_wdata <= '0;
            cfg_busy   <= 1'b0;
            cfg_done   <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            pv_q <= power_on_vd;
            // losing sensor power abandons the sequence; cfg_index is left for debug
            if (state != IDLE && !power_on_vd) begin
                state    <= IDLE;
                sccb_req <= 1'b0;
                cfg_busy <= 1'b0;
                cfg_done <= 1'b0;
                cfg_err  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (power_on_vd && !pv_q) begin
                        cfg_index <= '0;
                        retry     <= '0;
                        cfg_busy  <= 1'b1;
                        state     <= FETCH;
                    end
                    FETCH: state <= WAIT_ROM;
                    WAIT_ROM: begin
                        sccb_reg   <= rom_data[23:8];
                        sccb_wdata <= rom_data[7:0];
                        state      <= DECODE;
                    end
                    DECODE: if (sccb_reg == DELAY_MARK) begin
                        dly   <= 32'(sccb_wdata) * 32'(DELAY_UNIT);
                        state <= DELAY;
                    end else begin
                        sccb_req <= 1'b1;
                        state    <= REQ;
                    end
                    REQ: state <= WAIT_ACK;
                    WAIT_ACK: if (sccb_done) begin
                        sccb_req <= 1'b0;
                        if (!sccb_nack) state <= NEXT;
                        else if (int'(retry) + 1 < MAX_RETRY) begin
                            retry <= retry + RW'(1);
                            state <= GAP;
                        end else begin
                            cfg_busy <= 1'b0;
                            cfg_err  <= 1'b1;
                            state    <= ERR;
                        end
                    end
                    GAP: begin
                        sccb_req <= 1'b1;
                        state    <= REQ;
                    end
                    DELAY: if (dly == 0) state <= NEXT; else dly <= dly - 1;
                    NEXT: begin
                        retry <= '0;
                        if (cfg_index == ADDR_W'(TABLE_LEN - 1)) begin
                            cfg_busy <= 1'b0;
                            cfg_done <= 1'b1;
                            state    <= DONE;
                        end else begin
                            cfg_index <= cfg_index + ADDR_W'(1);
                            state     <= FETCH;
                        end
                    end
                    default: if (start_cfg) begin
                        cfg_index <= '0;
                        retry     <= '0;
                        cfg_busy  <= 1'b1;
                        cfg_done  <= 1'b0;
                        cfg_err   <= 1'b0;
                        state     <= FETCH;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sensor_cfg_seq.sv
// tb_sensor_cfg_seq: drives small register tables through sensor_cfg_seq with a
// randomised SCCB responder and compares the write stream to a table-level model.
module tb_sensor_cfg_seq;
    localparam int TL = 4, AW = 2, DU = 10, MR = 3;
    logic          clk = 0, rst = 1, power_on_vd = 0, start_cfg = 0, sccb_done = 0, sccb_nack = 0;
    logic [AW-1:0] rom_addr, cfg_index;
    logic [23:0]   rom_data = '0;
    logic          sccb_req, cfg_busy, cfg_done, cfg_err;
    logic [7:0]    sccb_dev, sccb_wdata;
    logic [15:0]   sccb_reg;
    int            errors = 0, checks = 0, cyc = 0, wcnt = 0, trig_cyc = 0;
    bit            slave_hold = 0, req_prev = 0;
    logic [23:0]   tbl [TL];
    int            nk [TL];
    logic [23:0]   log_q [$];
    int            start_cyc [$], done_cyc [$];
    bit            nack_q [$];

    sensor_cfg_seq #(.TABLE_LEN(TL), .ADDR_W(AW), .DEV_ADDR(8'h78), .DELAY_MARK(16'hFFFF),
                     .DELAY_UNIT(DU), .MAX_RETRY(MR)) dut (
        .clk(clk), .rst(rst), .power_on_vd(power_on_vd), .start_cfg(start_cfg),
        .rom_addr(rom_addr), .rom_data(rom_data), .sccb_req(sccb_req), .sccb_dev(sccb_dev),
        .sccb_reg(sccb_reg), .sccb_wdata(sccb_wdata), .sccb_done(sccb_done), .sccb_nack(sccb_nack),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .cfg_index(cfg_index));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) rom_data <= tbl[rom_addr];

    // SCCB responder: completes each request 1..4 cycles after it rises
    always @(negedge clk) begin
        if (rst) begin
            sccb_done = 0; sccb_nack = 0; req_prev = 0;
        end else begin
            sccb_done = 0; sccb_nack = 0;
            if (sccb_req && !req_prev) begin
                start_cyc.push_back(cyc);
                wcnt = int'($urandom_range(1, 4));
            end else if (sccb_req && !slave_hold && wcnt > 0) begin
                wcnt--;
                if (wcnt == 0) begin
                    log_q.push_back({sccb_reg, sccb_wdata});
                    done_cyc.push_back(cyc);
                    if (nack_q.size() > 0) sccb_nack = nack_q.pop_front();
                    sccb_done = 1;
                end
            end
            req_prev = sccb_req;
        end
    end

    // expected write attempts from the table and per-entry NACK counts
    task automatic model(output logic [23:0] exp [$], output int err_idx);
        exp = {}; err_idx = -1; nack_q = {};
        for (int i = 0; i < TL; i++) begin
            if (tbl[i][23:8] == 16'hFFFF) continue;
            for (int a = 0; a < MR; a++) begin
                exp.push_back(tbl[i]);
                nack_q.push_back(a < nk[i]);
                if (a >= nk[i]) break;
            end
            if (nk[i] >= MR) begin err_idx = i; break; end
        end
    endtask

    task automatic trig_power();
        @(negedge clk); power_on_vd = 0;
        repeat (2) @(negedge clk);
        power_on_vd = 1; trig_cyc = cyc;
    endtask

    task automatic trig_start();
        @(negedge clk); start_cfg = 1; trig_cyc = cyc;
        @(negedge clk); start_cfg = 0;
    endtask

    task automatic run_table(input string name, input bit via_start, input bit mid_start);
        logic [23:0] exp [$];
        int err_idx, n;
        model(exp, err_idx);
        log_q = {}; start_cyc = {}; done_cyc = {};
        if (via_start) trig_start(); else trig_power();
        if (mid_start) begin
            repeat (6) @(negedge clk);
            start_cfg = 1; @(negedge clk); start_cfg = 0;
        end
        n = 0;
        while (!(cfg_done || cfg_err) && n < 3000) begin @(negedge clk); n++; end
        checks++;
        if (!(cfg_done || cfg_err)) begin
            errors++; $display("FAIL %s finish: busy=%b done=%b err=%b, required done or err", name, cfg_busy, cfg_done, cfg_err);
        end
        checks++;
        if (log_q.size() != exp.size()) begin
            errors++; $display("FAIL %s write count: got %0d, expected %0d", name, log_q.size(), exp.size());
        end else
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (log_q[i] !== exp[i]) begin
                    errors++; $display("FAIL %s write %0d: got %h, expected %h", name, i, log_q[i], exp[i]);
                end
            end
        checks++;
        if (cfg_done !== (err_idx < 0) || cfg_err !== (err_idx >= 0)) begin
            errors++; $display("FAIL %s status: done=%b err=%b, expected err_idx=%0d", name, cfg_done, cfg_err, err_idx);
        end
        if (err_idx >= 0) begin
            checks++;
            if (cfg_index !== AW'(err_idx)) begin
                errors++; $display("FAIL %s err index: got %0d, expected %0d", name, cfg_index, err_idx);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1; power_on_vd = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({sccb_req, cfg_busy, cfg_done, cfg_err, cfg_index, rom_addr, sccb_reg, sccb_wdata} !== '0) begin
            errors++; $display("FAIL reset outputs: req=%b busy=%b done=%b err=%b idx=%0d, expected all 0", sccb_req, cfg_busy, cfg_done, cfg_err, cfg_index);
        end
        checks++;
        if (sccb_dev !== 8'h78) begin
            errors++; $display("FAIL reset dev: got %h, expected 78", sccb_dev);
        end
        rst = 0;
        @(negedge clk); start_cfg = 1;
        @(negedge clk); start_cfg = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (cfg_busy !== 0 || sccb_req !== 0) begin
            errors++; $display("FAIL idle start ignored: busy=%b req=%b, expected 0 0", cfg_busy, sccb_req);
        end
    endtask

    task automatic test_basic();
        tbl = '{24'h300802, 24'h310303, 24'h3017FF, 24'h3A0411};
        nk = '{0, 0, 0, 0};
        run_table("basic", 0, 0);
        checks++;
        if (start_cyc.size() == 0 || start_cyc[0] - trig_cyc != 4) begin
            errors++; $display("FAIL basic latency: got %0d, expected 4", start_cyc.size() ? start_cyc[0] - trig_cyc : -1);
        end
    endtask

    task automatic test_delay();
        tbl = '{24'h300802, 24'hFFFF05, 24'hFFFF00, 24'h3017FF};
        nk = '{0, 0, 0, 0};
        run_table("delay", 0, 0);
        checks++;
        if (start_cyc.size() != 2 || done_cyc.size() < 1 ||
            start_cyc[1] - done_cyc[0] < 5 * DU || start_cyc[1] - done_cyc[0] > 5 * DU + 30) begin
            errors++; $display("FAIL delay gap: reqs=%0d gap=%0d, expected 2 reqs and gap in [%0d,%0d]",
                start_cyc.size(), (start_cyc.size() == 2 && done_cyc.size() > 0) ? start_cyc[1] - done_cyc[0] : -1, 5 * DU, 5 * DU + 30);
        end
    endtask

    task automatic test_nack_once();
        tbl = '{24'h300802, 24'h310303, 24'h3017FF, 24'h3A0411};
        nk = '{0, 1, 0, 0};
        run_table("nack_once", 0, 0);
        checks++;
        if (start_cyc.size() < 3 || done_cyc.size() < 2 || start_cyc[2] - done_cyc[1] != 2) begin
            errors++; $display("FAIL nack_once regap: got %0d, expected 2", (start_cyc.size() > 2 && done_cyc.size() > 1) ? start_cyc[2] - done_cyc[1] : -1);
        end
    endtask

    task automatic test_nack_err();
        tbl = '{24'h300802, 24'h310303, 24'h3017FF, 24'h3A0411};
        nk = '{0, MR, 0, 0};
        run_table("nack_err", 0, 0);
        repeat (30) @(negedge clk);
        checks++;
        if (start_cyc.size() != 1 + MR || cfg_err !== 1) begin
            errors++; $display("FAIL nack_err hold: reqs=%0d err=%b, expected %0d and 1", start_cyc.size(), cfg_err, 1 + MR);
        end
    endtask

    task automatic test_abort();
        int n = 0;
        tbl = '{24'h300802, 24'h310303, 24'h3017FF, 24'h3A0411};
        nk = '{0, 0, 0, 0};
        slave_hold = 1;
        trig_power();
        while (!sccb_req && n < 50) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        power_on_vd = 0;
        @(negedge clk);
        checks++;
        if (sccb_req !== 0 || cfg_busy !== 0 || n >= 50) begin
            errors++; $display("FAIL abort: req=%b busy=%b wait=%0d, expected 0 0 and req seen", sccb_req, cfg_busy, n);
        end
        slave_hold = 0;
        run_table("abort_restart", 0, 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < TL; i++) begin
                tbl[i] = ($urandom_range(0, 4) == 0) ? {16'hFFFF, 8'($urandom_range(0, 2))}
                                                    : {16'($urandom_range(0, 16'hFFFE)), 8'($urandom)};
                nk[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, MR)) : 0;
            end
            run_table("random", it[0], 0);
        end
    endtask

    task automatic test_start();
        int n = 0;
        tbl = '{24'h300802, 24'h310303, 24'h3017FF, 24'h3A0411};
        nk = '{0, 0, 0, 0};
        run_table("busy_start", 0, 1);
        run_table("rerun", 1, 0);
        start_cyc = {};
        trig_start();
        while (start_cyc.size() < 2 && n < 200) begin @(negedge clk); n++; end
        #2 rst = 1;
        #1;
        checks++;
        if ({sccb_req, cfg_busy, cfg_done, cfg_err, cfg_index, sccb_reg, sccb_wdata} !== '0 || sccb_dev !== 8'h78) begin
            errors++; $display("FAIL async rst: req=%b busy=%b idx=%0d reg=%h dev=%h, expected zeros and dev 78", sccb_req, cfg_busy, cfg_index, sccb_reg, sccb_dev);
        end
        power_on_vd = 0;
        @(negedge clk); rst = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_delay();
        test_nack_once();
        test_nack_err();
        test_abort();
        test_random();
        test_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
